// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared memory port.
// The arbiter takes the slave view; clients and memory together take the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch and a data
// requester; one transaction at a time with a per-transaction timeout.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          sel_data;
    logic          in_busy;
    logic          in_resp;

    // Data wins when it is the only requester, or on a tie after a fetch grant.
    assign sel_data = bus.d_req & (~bus.i_req | (last_q == OWN_I));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req | bus.d_req) begin
                    owner_d = sel_data ? OWN_D : OWN_I;
                    last_d  = sel_data ? OWN_D : OWN_I;
                    addr_d  = sel_data ? bus.d_addr : bus.i_addr;
                    we_d    = sel_data & bus.d_we;
                    wdata_d = sel_data ? bus.d_wdata : '0;
                    cnt_d   = 8'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Captured transaction fields need no reset: every output is gated by state.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    assign in_busy = (state_q == S_BUSY);
    assign in_resp = (state_q == S_RESP);

    assign bus.mem_req   = in_busy;
    assign bus.mem_we    = in_busy & we_q;
    assign bus.mem_addr  = in_busy ? addr_q : '0;
    assign bus.mem_wdata = in_busy ? wdata_q : '0;

    assign bus.i_ack   = in_resp & (owner_q == OWN_I);
    assign bus.i_rdata = bus.i_ack ? rdata_q : '0;
    assign bus.i_err   = bus.i_ack & err_q;

    assign bus.d_ack   = in_resp & (owner_q == OWN_D);
    assign bus.d_rdata = bus.d_ack ? rdata_q : '0;
    assign bus.d_err   = bus.d_ack & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: one open transaction or one response cycle at a time.
    bit            m_busy   = 1'b0;
    bit            m_resp   = 1'b0;
    bit            m_last_d = 1'b0;
    bit            m_sel_d  = 1'b0;
    bit            m_we     = 1'b0;
    bit            m_err    = 1'b0;
    int            m_edge   = 0;
    int            m_grant_edge = 0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_rdata  = '0;

    always @(posedge clk) begin
        m_edge = m_edge + 1;
        if (rst) begin
            m_busy   = 1'b0;
            m_resp   = 1'b0;
            m_last_d = 1'b0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_busy) begin
            if (bus.mem_ready) begin
                m_busy  = 1'b0;
                m_resp  = 1'b1;
                m_err   = 1'b0;
                m_rdata = m_we ? '0 : bus.mem_rdata;
            end else if (m_edge - m_grant_edge == TIMEOUT) begin
                m_busy  = 1'b0;
                m_resp  = 1'b1;
                m_err   = 1'b1;
                m_rdata = '0;
            end
        end else if (bus.i_req || bus.d_req) begin
            if (bus.i_req && bus.d_req) m_sel_d = !m_last_d;
            else                        m_sel_d = bus.d_req;
            m_last_d     = m_sel_d;
            m_busy       = 1'b1;
            m_grant_edge = m_edge;
            m_addr       = m_sel_d ? bus.d_addr : bus.i_addr;
            m_we         = m_sel_d && bus.d_we;
            m_wdata      = m_sel_d ? bus.d_wdata : '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_ctl", 64'({bus.mem_req, bus.mem_we}), 64'({m_busy, m_busy && m_we}));
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_busy ? m_addr : '0));
            if (!m_busy || m_we)
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_busy ? m_wdata : '0));
            chk("i_resp", 64'({bus.i_ack, bus.i_err, bus.i_rdata}),
                64'((m_resp && !m_sel_d) ? {1'b1, m_err, m_rdata} : '0));
            chk("d_resp", 64'({bus.d_ack, bus.d_err, bus.d_rdata}),
                64'((m_resp && m_sel_d) ? {1'b1, m_err, m_rdata} : '0));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        bit order_q[$];
        int ack_cyc[$];
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (2) step();
        chk_en = 1'b1;
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_acks", 64'({bus.i_ack, bus.d_ack}), 64'd0);
        rst = 1'b0;
        step();

        // Fetch read with memory ready two cycles after mem_req rises.
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        step();
        chk("fetch_mem_req", 64'(bus.mem_req), 64'd1);
        chk("fetch_mem_we", 64'(bus.mem_we), 64'd0);
        chk("fetch_mem_addr", 64'(bus.mem_addr), 64'h100);
        step();
        step();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        bus.mem_ready = 1'b0; bus.i_req = 1'b0;
        chk("fetch_i_ack", 64'(bus.i_ack), 64'd1);
        chk("fetch_i_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);
        chk("fetch_i_err", 64'(bus.i_err), 64'd0);
        chk("fetch_d_ack", 64'(bus.d_ack), 64'd0);
        step();
        chk("fetch_ack_pulse", 64'(bus.i_ack), 64'd0);

        // Store: write data presented, read data returned as zero.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
        step();
        chk("store_mem_we", 64'(bus.mem_we), 64'd1);
        chk("store_mem_addr", 64'(bus.mem_addr), 64'h200);
        chk("store_mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        step();
        bus.mem_ready = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        chk("store_d_ack", 64'(bus.d_ack), 64'd1);
        chk("store_d_rdata", 64'(bus.d_rdata), 64'd0);
        chk("store_d_err", 64'(bus.d_err), 64'd0);
        chk("store_i_ack", 64'(bus.i_ack), 64'd0);
        step();

        // Timeout: memory never answers.
        bus.d_req = 1'b1; bus.d_addr = 32'h300;
        step();
        n = 0;
        while (bus.mem_req && n < 20) begin
            n++;
            step();
        end
        chk("timeout_busy_cycles", 64'(n), 64'd4);
        chk("timeout_d_ack", 64'(bus.d_ack), 64'd1);
        chk("timeout_d_err", 64'(bus.d_err), 64'd1);
        chk("timeout_d_rdata", 64'(bus.d_rdata), 64'd0);
        bus.d_req = 1'b0;
        step();

        // Ready on the last allowed BUSY cycle completes normally.
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        repeat (4) step();
        chk("lastcyc_mem_req", 64'(bus.mem_req), 64'd1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        step();
        bus.mem_ready = 1'b0; bus.i_req = 1'b0;
        chk("lastcyc_i_ack", 64'(bus.i_ack), 64'd1);
        chk("lastcyc_i_err", 64'(bus.i_err), 64'd0);
        chk("lastcyc_i_rdata", 64'(bus.i_rdata), 64'hCAFEF00D);
        step();

        // Reset in the middle of BUSY, then a stray ready.
        bus.d_req = 1'b1; bus.d_addr = 32'h500;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
        chk("abort_mem_req", 64'(bus.mem_req), 64'd0);
        chk("abort_d_ack", 64'(bus.d_ack), 64'd0);
        step();
        bus.mem_ready = 1'b0;
        chk("abort_stray_ready", 64'({bus.mem_req, bus.d_ack, bus.i_ack}), 64'd0);
        step();
        chk("abort_no_late_ack", 64'({bus.d_ack, bus.i_ack}), 64'd0);

        // Both requesters held high after reset: strict alternation starting with data.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.i_addr = 32'h600; bus.d_addr = 32'h700;
        cyc = 0;
        while (order_q.size() < 4 && cyc < 60) begin
            step();
            cyc++;
            bus.mem_ready = bus.mem_req;
            bus.mem_rdata = $urandom;
            if (bus.i_ack) begin order_q.push_back(1'b0); ack_cyc.push_back(cyc); end
            if (bus.d_ack) begin order_q.push_back(1'b1); ack_cyc.push_back(cyc); end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        chk("rr_ack_count", 64'(order_q.size()), 64'd4);
        if (order_q.size() == 4) begin
            chk("rr_order_DIDI", 64'({order_q[0], order_q[1], order_q[2], order_q[3]}), 64'b1010);
            chk("rr_span", 64'(ack_cyc[3] - ack_cyc[0]), 64'd9);
        end
        step();

        // Random traffic, including stray readies, mid-transaction input churn and resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (bus.mem_req) bus.mem_ready = ($urandom_range(0, 2) == 0);
            else             bus.mem_ready = ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
            if (bus.i_ack) begin
                bus.i_req = 1'b0;
            end else if (bus.i_req && (m_busy || m_resp) && !m_sel_d) begin
                bus.i_addr = $urandom;
            end else if (!bus.i_req && $urandom_range(0, 1) == 1) begin
                bus.i_req = 1'b1; bus.i_addr = $urandom;
            end
            if (bus.d_ack) begin
                bus.d_req = 1'b0;
            end else if (bus.d_req && (m_busy || m_resp) && m_sel_d) begin
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 7) == 0) bus.d_req = 1'b0;
            end else if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                bus.d_req = 1'b1; bus.d_we = $urandom_range(0, 1) == 1;
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
